// File: rtl/x25519_ladder_ctrl_if.sv
// rtl/x25519_ladder_ctrl_if.sv - handshake bundle between wrapper, ladder controller and step/inverter units
interface x25519_ladder_ctrl_if;
    logic         start;
    logic [255:0] scalar;
    logic         busy;
    logic [7:0]   bit_index;
    logic         cswap_valid;
    logic         cswap_bit;
    logic         step_start;
    logic         step_done;
    logic         inv_start;
    logic         inv_done;
    logic         done;

    modport master (
        output start, scalar, step_done, inv_done,
        input  busy, bit_index, cswap_valid, cswap_bit, step_start, inv_start, done
    );

    modport slave (
        input  start, scalar, step_done, inv_done,
        output busy, bit_index, cswap_valid, cswap_bit, step_start, inv_start, done
    );
endinterface

// File: rtl/x25519_ladder_ctrl.sv
// rtl/x25519_ladder_ctrl.sv - Montgomery-ladder sequencer: clamp, per-bit cswap + step, final cswap, z inversion
module x25519_ladder_ctrl #(
    parameter int BITS  = 255,
    parameter bit CLAMP = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    x25519_ladder_ctrl_if.slave   bus
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_LOAD       = 4'd1;
    localparam logic [3:0] S_SWAP       = 4'd2;
    localparam logic [3:0] S_STEP_REQ   = 4'd3;
    localparam logic [3:0] S_STEP_WAIT  = 4'd4;
    localparam logic [3:0] S_FINAL_SWAP = 4'd5;
    localparam logic [3:0] S_INV_REQ    = 4'd6;
    localparam logic [3:0] S_INV_WAIT   = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

    localparam logic [7:0] IDX_TOP = 8'(BITS - 1);

    logic [3:0]   state;
    logic [3:0]   next_state;
    logic [7:0]   bit_index;
    logic [7:0]   next_idx;
    logic [255:0] k;
    logic [255:0] k_load;
    logic         k_bit;
    logic         swap_state;
    logic         busy;
    logic         cswap_valid;
    logic         cswap_bit;
    logic         step_start;
    logic         inv_start;
    logic         done;

    always_comb begin
        k_load = bus.scalar;
        if (CLAMP) begin
            k_load[2:0] = 3'b000;
            k_load[255] = 1'b0;
            k_load[254] = 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        next_idx   = bit_index;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    next_state = S_LOAD;
                    next_idx   = IDX_TOP;
                end
            end
            S_LOAD:       next_state = S_SWAP;
            S_SWAP:       next_state = S_STEP_REQ;
            S_STEP_REQ:   next_state = S_STEP_WAIT;
            S_STEP_WAIT: begin
                if (bus.step_done) begin
                    if (bit_index == 8'd0) begin
                        next_state = S_FINAL_SWAP;
                    end else begin
                        next_idx   = bit_index - 8'd1;
                        next_state = S_SWAP;
                    end
                end
            end
            S_FINAL_SWAP: next_state = S_INV_REQ;
            S_INV_REQ:    next_state = S_INV_WAIT;
            S_INV_WAIT: begin
                if (bus.inv_done) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:       next_state = S_IDLE;
            default:      next_state = S_IDLE;
        endcase
    end

    // Command outputs are decoded from the next state so each is a flop that is high for the state's single cycle.
    assign k_bit = k[next_idx];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            bit_index   <= 8'd0;
            k           <= '0;
            swap_state  <= 1'b0;
            busy        <= 1'b0;
            cswap_valid <= 1'b0;
            cswap_bit   <= 1'b0;
            step_start  <= 1'b0;
            inv_start   <= 1'b0;
            done        <= 1'b0;
        end else begin
            state     <= next_state;
            bit_index <= next_idx;
            if (state == S_IDLE && bus.start) begin
                k          <= k_load;
                swap_state <= 1'b0;
            end else if (next_state == S_SWAP) begin
                swap_state <= k_bit;
            end
            busy        <= (next_state != S_IDLE);
            cswap_valid <= (next_state == S_SWAP) || (next_state == S_FINAL_SWAP);
            if (next_state == S_SWAP) begin
                cswap_bit <= swap_state ^ k_bit;
            end else if (next_state == S_FINAL_SWAP) begin
                cswap_bit <= swap_state;
            end else begin
                cswap_bit <= 1'b0;
            end
            step_start <= (next_state == S_STEP_REQ);
            inv_start  <= (next_state == S_INV_REQ);
            done       <= (next_state == S_DONE);
        end
    end

    assign bus.busy        = busy;
    assign bus.bit_index   = bit_index;
    assign bus.cswap_valid = cswap_valid;
    assign bus.cswap_bit   = cswap_bit;
    assign bus.step_start  = step_start;
    assign bus.inv_start   = inv_start;
    assign bus.done        = done;

endmodule

// File: tb/tb_x25519_ladder_ctrl.sv
// tb/tb_x25519_ladder_ctrl.sv - scoreboard bench for the X25519 ladder sequencer
module tb_x25519_ladder_ctrl;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    x25519_ladder_ctrl_if ia();
    x25519_ladder_ctrl_if ib();

    x25519_ladder_ctrl #(.BITS(255), .CLAMP(1'b1)) dut_a (.clock(clock), .reset_n(reset_n), .bus(ia));
    x25519_ladder_ctrl #(.BITS(255), .CLAMP(1'b0)) dut_b (.clock(clock), .reset_n(reset_n), .bus(ib));

    logic         sel = 1'b0;
    logic         st  = 1'b0;
    logic         sd  = 1'b1;
    logic         id  = 1'b1;
    logic [255:0] sc  = '0;

    assign ia.start     = st & ~sel;
    assign ib.start     = st & sel;
    assign ia.scalar    = sc;
    assign ib.scalar    = sc;
    assign ia.step_done = sd;
    assign ib.step_done = sd;
    assign ia.inv_done  = id;
    assign ib.inv_done  = id;

    logic       m_busy, m_cswap_valid, m_cswap_bit, m_step_start, m_inv_start, m_done;
    logic [7:0] m_bit_index;
    assign m_busy        = sel ? ib.busy        : ia.busy;
    assign m_bit_index   = sel ? ib.bit_index   : ia.bit_index;
    assign m_cswap_valid = sel ? ib.cswap_valid : ia.cswap_valid;
    assign m_cswap_bit   = sel ? ib.cswap_bit   : ia.cswap_bit;
    assign m_step_start  = sel ? ib.step_start  : ia.step_start;
    assign m_inv_start   = sel ? ib.inv_start   : ia.inv_start;
    assign m_done        = sel ? ib.done        : ia.done;

    typedef struct { int idx; bit b; } cs_t;
    typedef struct { int lat; int ones; } op_t;
    cs_t cs_q[$];
    int  step_q[$];
    op_t op_q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int c0     = 0;
    int dly    = 0;
    bit op_done = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - c0);
        end
    endtask

    // Monitor: pops expected commands as the DUT issues them; also plays the step unit when a delay is set.
    int  nstep = 0, ncs = 0, ninv = 0, ones = 0, cnt = 0;
    bit  pending = 1'b0;
    always @(negedge clock) begin
        cs_t e;
        op_t o;
        int  s;
        if (!reset_n) begin
            nstep = 0; ncs = 0; ninv = 0; ones = 0; cnt = 0; pending = 1'b0;
        end else begin
            if (sd) pending = 1'b0;
            if (m_cswap_valid) begin
                ncs++;
                if (m_cswap_bit) ones++;
                if (cs_q.size() == 0) check("unexpected_cswap", 1, 0);
                else begin
                    e = cs_q.pop_front();
                    check("cswap_idx", m_bit_index, e.idx);
                    check("cswap_bit", m_cswap_bit, e.b);
                end
            end
            if (m_step_start) begin
                nstep++;
                check("step_before_done", pending, 0);
                pending = 1'b1;
                if (step_q.size() == 0) check("unexpected_step", 1, 0);
                else begin
                    s = step_q.pop_front();
                    check("step_idx", m_bit_index, s);
                end
            end
            if (m_inv_start) ninv++;
            if (m_done) begin
                if (op_q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    o = op_q.pop_front();
                    check("latency", cyc - c0, o.lat);
                    check("ones", ones, o.ones);
                end
                check("step_pulses", nstep, 255);
                check("cswap_pulses", ncs, 256);
                check("inv_pulses", ninv, 1);
                check("busy_at_done", m_busy, 1);
                check("cswap_left", cs_q.size(), 0);
                check("step_left", step_q.size(), 0);
                nstep = 0; ncs = 0; ninv = 0; ones = 0;
                op_done = 1'b1;
            end
            if (dly == 0) sd = 1'b1;
            else begin
                sd = 1'b0;
                if (m_step_start) cnt = dly;
                else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) sd = 1'b1;
                end
            end
        end
    end

    task automatic check_quiet(input string name);
        check({name, "_busy"}, m_busy, 0);
        check({name, "_idx"}, m_bit_index, 0);
        check({name, "_pulses"}, {m_cswap_valid, m_cswap_bit, m_step_start, m_inv_start, m_done}, 0);
    endtask

    task automatic run_op(input logic [255:0] k, input bit use_b, input int d, input int lat,
                          input int n_ones, input int restart_at, input int reset_at);
        logic [255:0] kk;
        bit sw;
        bit aborted;
        int rel;
        kk = k;
        if (!use_b) begin
            kk[2:0] = 3'b000;
            kk[255] = 1'b0;
            kk[254] = 1'b1;
        end
        sw = 1'b0;
        for (int i = 254; i >= 0; i--) begin
            cs_q.push_back('{i, sw ^ kk[i]});
            step_q.push_back(i);
            sw = kk[i];
        end
        cs_q.push_back('{0, sw});
        if (reset_at < 0) op_q.push_back('{lat, n_ones});
        sel = use_b;
        dly = d;
        op_done = 1'b0;
        aborted = 1'b0;
        @(negedge clock); #1;
        c0 = cyc;
        sc = k;
        st = 1'b1;
        for (int n = 0; n < lat + 50 && !op_done && !aborted; n++) begin
            @(negedge clock); #1;
            rel = cyc - c0;
            st = (rel == restart_at);
            sc = ~k;
            if (rel == reset_at) begin
                reset_n = 1'b0;
                #1;
                check_quiet("midop_reset");
                cs_q.delete();
                step_q.delete();
                repeat (2) @(negedge clock);
                reset_n = 1'b1;
                aborted = 1'b1;
            end
        end
        st = 1'b0;
        if (!aborted) begin
            check("op_complete", op_done, 1);
            @(negedge clock); #1;
            check("idle_after_done", m_busy, 0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        sel = 1'b0; #1; check_quiet("reset_a");
        sel = 1'b1; #1; check_quiet("reset_b");
        sel = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        run_op(256'h0, 1'b0, 0, 770, 2, -1, -1);
        run_op({256{1'b1}}, 1'b0, 0, 770, 2, -1, -1);
        run_op(256'h0, 1'b0, 5, 1790, 2, -1, -1);
        run_op(256'h0, 1'b0, 0, 770, 2, 100, -1);
        run_op(256'h0, 1'b0, 0, 770, 2, -1, 300);
        run_op(256'h0, 1'b0, 0, 770, 2, -1, -1);
        run_op(256'h1, 1'b1, 0, 770, 2, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
